// File: rtl/ex_mem_stage_reg_if.sv
// EX/MEM stage handshake bundle: EX-side producer inputs, MEM-side consumer outputs.
// The master modport is the environment (EX + MEM); the slave modport is the stage register.
interface ex_mem_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_wr_data;
  logic [REG_W-1:0]  ex_wr_reg;
  logic [3:0]        ex_ctrl;
  logic              mem_valid;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_wr_data;
  logic [REG_W-1:0]  mem_wr_reg;
  logic [3:0]        mem_ctrl;
  logic [1:0]        occupancy;

  modport master (
    output ex_valid, ex_alu_result, ex_wr_data, ex_wr_reg, ex_ctrl, mem_ready,
    input  ex_ready, mem_valid, mem_alu_result, mem_wr_data, mem_wr_reg, mem_ctrl, occupancy
  );

  modport slave (
    input  ex_valid, ex_alu_result, ex_wr_data, ex_wr_reg, ex_ctrl, mem_ready,
    output ex_ready, mem_valid, mem_alu_result, mem_wr_data, mem_wr_reg, mem_ctrl, occupancy
  );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer (main = head, skid = second) and sync flush.
// Optional macro EXMEM_ZERO_REG_SQUASH_EN clears the stored reg_write bit when the destination is $zero.
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  ex_mem_stage_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  // ctrl layout: {reg_write, mem_read, mem_write, mem_to_reg}
  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] wr_data;
    logic [REG_W-1:0]  wr_reg;
    logic [3:0]        ctrl;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  state_e     state_q;
  state_e     state_d;
  entry_t     main_q;
  entry_t     main_d;
  entry_t     skid_q;
  entry_t     skid_d;
  entry_t     in_entry_s;
  logic       ex_ready_s;
  logic       mem_valid_s;
  logic [1:0] occupancy_s;
  logic       accept_s;
  logic       pop_s;

  assign accept_s = bus.ex_valid & ex_ready_s;
  assign pop_s    = mem_valid_s & bus.mem_ready;

  // Capture the incoming EX payload, optionally squashing writes to $zero.
  always_comb begin
    in_entry_s.alu_result = bus.ex_alu_result;
    in_entry_s.wr_data    = bus.ex_wr_data;
    in_entry_s.wr_reg     = bus.ex_wr_reg;
    in_entry_s.ctrl       = bus.ex_ctrl;
`ifdef EXMEM_ZERO_REG_SQUASH_EN
    if (bus.ex_wr_reg == {REG_W{1'b0}}) begin
      in_entry_s.ctrl[3] = 1'b0;
    end else begin
      in_entry_s.ctrl[3] = bus.ex_ctrl[3];
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers; stale contents after flush are harmless since outputs are gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= entry_t'({ENTRY_W{1'b0}});
      skid_q <= entry_t'({ENTRY_W{1'b0}});
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Next state and payload steering; flush wins over any accept or pop.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept_s) begin
            state_d = S_ONE;
            main_d  = in_entry_s;
          end else begin
            state_d = S_EMPTY;
          end
        end
        S_ONE: begin
          if (accept_s && pop_s) begin
            state_d = S_ONE;
            main_d  = in_entry_s;
          end else if (accept_s) begin
            state_d = S_FULL;
            skid_d  = in_entry_s;
          end else if (pop_s) begin
            state_d = S_EMPTY;
          end else begin
            state_d = S_ONE;
          end
        end
        S_FULL: begin
          if (pop_s) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end else begin
            state_d = S_FULL;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only, so ex_ready never depends on mem_ready.
  always_comb begin
    ex_ready_s  = 1'b1;
    mem_valid_s = 1'b0;
    occupancy_s = 2'd0;
    case (state_q)
      S_EMPTY: begin
        ex_ready_s  = 1'b1;
        mem_valid_s = 1'b0;
        occupancy_s = 2'd0;
      end
      S_ONE: begin
        ex_ready_s  = 1'b1;
        mem_valid_s = 1'b1;
        occupancy_s = 2'd1;
      end
      S_FULL: begin
        ex_ready_s  = 1'b0;
        mem_valid_s = 1'b1;
        occupancy_s = 2'd2;
      end
      default: begin
        ex_ready_s  = 1'b0;
        mem_valid_s = 1'b0;
        occupancy_s = 2'd0;
      end
    endcase
  end

  assign bus.ex_ready       = ex_ready_s;
  assign bus.mem_valid      = mem_valid_s;
  assign bus.occupancy      = occupancy_s;
  assign bus.mem_alu_result = main_q.alu_result;
  assign bus.mem_wr_data    = main_q.wr_data;
  assign bus.mem_wr_reg     = main_q.wr_reg;
  assign bus.mem_ctrl       = main_q.ctrl & {4{mem_valid_s}};

endmodule
